led_seq: RTL and testbench

Parametrised LED sequencer for N_LED LEDs, successor to the fixed 4-LED bounce blinker. It has a programmable step period, four selectable patterns (bounce, rotate, blink-all, binary count), pause, and PWM brightness. It sits at board top level, driven by the system clock, with LED wired straight to pins.

---
 rtl/led_seq_pkg.sv | 8 +
 rtl/led_prescaler.sv | 18 +
 rtl/led_seq.sv | 83 ++++++++
 tb/tb_led_seq.sv | 136 +++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// led_seq_pkg: mode encodings and bounce direction shared by the LED sequencer
package led_seq_pkg;
  localparam logic [1:0] MODE_BOUNCE = 2'd0;
  localparam logic [1:0] MODE_ROTATE = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_BINARY = 2'd3;
  typedef enum logic {UP, DOWN} dir_t;
endpackage

// File: rtl/led_prescaler.sv
// led_prescaler: DIV+1 cycle tick generator with pause and synchronous clear
module led_prescaler #(
  parameter int DIV_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] div,
  input  logic             pause,
  input  logic             clr,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  always_comb tick = !pause && cnt >= div;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (!pause) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/led_seq.sv
// led_seq: N_LED pattern sequencer (bounce/rotate/blink/binary) with pause and PWM brightness
module led_seq
  import led_seq_pkg::*;
#(
  parameter int N_LED = 4,
  parameter int DIV_W = 23,
  parameter int PWM_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       MODE,
  input  logic             MODE_VLD,
  input  logic [DIV_W-1:0] DIV,
  input  logic             PAUSE,
  input  logic [PWM_W-1:0] BRIGHT,
  output logic [N_LED-1:0] LED,
  output logic             STEP
);
  localparam int PW = N_LED > 1 ? $clog2(N_LED) : 1;
  localparam logic [PW-1:0] LAST = PW'(N_LED - 1);
  logic             tick;
  logic [1:0]       mode_q;
  logic [PW-1:0]    pos;
  dir_t             dir;
  logic             phase;
  logic [N_LED-1:0] count;
  logic [N_LED-1:0] pattern;
  logic [PWM_W-1:0] pwm_cnt;
  logic             en;
  led_prescaler #(.DIV_W(DIV_W)) u_pre (
    .clk  (CLK),
    .rst  (RST),
    .div  (DIV),
    .pause(PAUSE),
    .clr  (MODE_VLD),
    .tick (tick)
  );
  always_comb begin
    pattern = mode_q == MODE_BLINK  ? {N_LED{phase}} :
              mode_q == MODE_BINARY ? count : N_LED'(1) << pos;
    en = (&BRIGHT) || (pwm_cnt < BRIGHT);
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      mode_q <= MODE_BOUNCE;
      pos    <= '0;
      dir    <= UP;
      phase  <= 1'b0;
      count  <= '0;
    end else if (MODE_VLD) begin
      mode_q <= MODE;
      pos    <= '0;
      dir    <= UP;
      phase  <= 1'b0;
      count  <= '0;
    end else if (tick) begin
      if (mode_q == MODE_BOUNCE) begin
        if (N_LED == 1) pos <= '0;
        else if (dir == UP) begin
          if (pos == LAST) begin
            dir <= DOWN;
            pos <= LAST - 1'b1;
          end else pos <= pos + 1'b1;
        end else if (pos == '0) begin
          dir <= UP;
          pos <= PW'(1);
        end else pos <= pos - 1'b1;
      end else if (mode_q == MODE_ROTATE) pos <= pos == LAST ? '0 : pos + 1'b1;
      else if (mode_q == MODE_BLINK) phase <= ~phase;
      else count <= count + 1'b1;
    end
  // a tick coinciding with a mode change is discarded, so it must not pulse STEP
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      pwm_cnt <= '0;
      LED     <= '0;
      STEP    <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      LED     <= en ? pattern : '0;
      STEP    <= tick && !MODE_VLD;
    end
endmodule

// File: tb/tb_led_seq.sv
// tb_led_seq: directed self-checking bench for led_seq (N_LED=4, PWM_W=4)
module tb_led_seq;
  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  MODE;
  logic        MODE_VLD;
  logic [22:0] DIV;
  logic        PAUSE;
  logic [3:0]  BRIGHT;
  logic [3:0]  LED;
  logic        STEP;
  int checks = 0;
  int errors = 0;
  int n;
  logic [3:0] bseq [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [3:0] rseq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] bri  [3] = '{4'h0, 4'h4, 4'hF};
  int         lit  [3] = '{0, 8, 32};

  led_seq #(.N_LED(4), .DIV_W(23), .PWM_W(4)) dut (
    .CLK(CLK), .RST(RST), .MODE(MODE), .MODE_VLD(MODE_VLD), .DIV(DIV),
    .PAUSE(PAUSE), .BRIGHT(BRIGHT), .LED(LED), .STEP(STEP)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int c);
    repeat (c) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    RST = 1'b1; MODE = 2'd0; MODE_VLD = 1'b0; DIV = 23'd3; PAUSE = 1'b0; BRIGHT = 4'hF;
    step(2);
    check("rst_led", 32'(LED), 32'h0);
    check("rst_step", 32'(STEP), 32'h0);
    RST = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      step(1);
      check("bounce_led", 32'(LED), 32'(bseq[(k - 1) / 4]));
      check("bounce_step", 32'(STEP), 32'(k % 4 == 0));
    end
    step(7);
    MODE = 2'd1; MODE_VLD = 1'b1;
    step(1);
    MODE_VLD = 1'b0;
    check("chg_led", 32'(LED), 32'h4);
    check("chg_step_discard", 32'(STEP), 32'h0);
    for (int j = 1; j <= 17; j++) begin
      step(1);
      check("rot_led", 32'(LED), 32'(rseq[(j - 1) / 4]));
      check("rot_step", 32'(STEP), 32'(j % 4 == 0));
    end
    DIV = 23'd0; MODE = 2'd3; MODE_VLD = 1'b1;
    step(1);
    MODE_VLD = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step(1);
      check("bin_led", 32'(LED), 32'((k - 1) % 16));
      check("bin_step", 32'(STEP), 32'h1);
    end
    MODE = 2'd2; MODE_VLD = 1'b1;
    step(1);
    MODE_VLD = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check("blink_led", 32'(LED), (k % 2 == 0) ? 32'hF : 32'h0);
    end
    DIV = 23'd3; MODE = 2'd0; MODE_VLD = 1'b1;
    step(1);
    MODE_VLD = 1'b0;
    step(9);
    check("pre_pause_led", 32'(LED), 32'h4);
    PAUSE = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1);
      check("pause_led", 32'(LED), 32'h4);
      check("pause_step", 32'(STEP), 32'h0);
    end
    PAUSE = 1'b0;
    step(1);
    check("resume_step1", 32'(STEP), 32'h0);
    step(1);
    check("resume_step2", 32'(STEP), 32'h0);
    step(1);
    check("resume_step3", 32'(STEP), 32'h1);
    check("resume_led3", 32'(LED), 32'h4);
    step(1);
    check("resume_led4", 32'(LED), 32'h8);
    DIV = 23'd100; MODE = 2'd0; MODE_VLD = 1'b1;
    step(1);
    MODE_VLD = 1'b0;
    step(50);
    check("div100_step", 32'(STEP), 32'h0);
    check("div100_led", 32'(LED), 32'h1);
    DIV = 23'd5;
    for (int o = 0; o <= 12; o++) begin
      step(1);
      check("div5_step", 32'(STEP), 32'(o % 6 == 0));
    end
    MODE = 2'd1; MODE_VLD = 1'b1; DIV = 23'd1000; BRIGHT = 4'h0;
    step(1);
    MODE_VLD = 1'b0;
    step(1);
    for (int b = 0; b < 3; b++) begin
      BRIGHT = bri[b];
      n = 0;
      for (int k = 0; k < 32; k++) begin
        step(1);
        if (LED != 4'h0) n++;
      end
      check("pwm_lit", 32'(n), 32'(lit[b]));
    end
    step(3);
    check("pre_rst_led", 32'(LED), 32'h1);
    #2 RST = 1'b1;
    #1;
    check("async_rst_led", 32'(LED), 32'h0);
    check("async_rst_step", 32'(STEP), 32'h0);
    step(2);
    RST = 1'b0;
    step(1);
    check("post_rst_led", 32'(LED), 32'h1);
    check("post_rst_step", 32'(STEP), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
